// File: rtl/sram_arb_pkg.sv
// Shared sizing and the round-robin pointer encoding for the SRAM buffer arbiter.
package sram_arb_pkg;
    localparam int NUM_BANKS = 4;
    localparam int BANK_GAP  = 5;
    localparam int RD_LAT    = 5;
    localparam int ADDR_W    = 10;
    localparam int LANE_W    = 64;

    typedef enum logic {
        PTR_RD = 1'b0,
        PTR_WR = 1'b1
    } rr_ptr_e;
endpackage

// File: rtl/sram_arbiter_bank_timer.sv
// Per-bank lockout timer: reloads on every issue to the bank and counts down to idle.
module sram_bank_timer #(
    parameter int GAP = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_busy
);
    localparam int CW = $clog2(GAP + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(GAP);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = (r_cnt != '0);
endmodule

// File: rtl/sram_arbiter.sv
// Read/write arbiter for a banked SRAM buffer: combinational grant, per-bank
// lockout after every issue, and a fixed-latency read return pipe.
//   state  | meaning
//   PTR_RD | read wins when both requesters are eligible
//   PTR_WR | write wins when both requesters are eligible
module sram_arbiter #(
    parameter int NUM_BANKS = sram_arb_pkg::NUM_BANKS,
    parameter int BANK_GAP  = sram_arb_pkg::BANK_GAP,
    parameter int RD_LAT    = sram_arb_pkg::RD_LAT
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        rd_req,
    input  logic [sram_arb_pkg::ADDR_W-1:0]             rd_addr,
    input  logic [NUM_BANKS-1:0]                        rd_mask,
    output logic                                        rd_gnt,
    output logic                                        rd_valid,
    output logic [NUM_BANKS-1:0]                        rd_vmask,
    output logic [NUM_BANKS*sram_arb_pkg::LANE_W-1:0]   rd_data,
    input  logic                                        wr_req,
    input  logic [sram_arb_pkg::ADDR_W-1:0]             wr_addr,
    input  logic [NUM_BANKS-1:0]                        wr_mask,
    input  logic [NUM_BANKS*sram_arb_pkg::LANE_W-1:0]   wr_data,
    output logic                                        wr_gnt,
    output logic                                        sram_ren,
    output logic                                        sram_wen,
    output logic [sram_arb_pkg::ADDR_W-1:0]             sram_addr,
    output logic [NUM_BANKS-1:0]                        sram_cs,
    output logic [NUM_BANKS*sram_arb_pkg::LANE_W-1:0]   sram_wdata,
    input  logic [NUM_BANKS*sram_arb_pkg::LANE_W-1:0]   sram_rdata,
    output logic [NUM_BANKS-1:0]                        bank_busy,
    output logic                                        mask_err
);
    import sram_arb_pkg::*;

    rr_ptr_e              r_ptr;
    rr_ptr_e              w_ptr_nxt;
    logic                 w_rd_elig;
    logic                 w_wr_elig;
    logic                 w_rd_gnt;
    logic                 w_wr_gnt;
    logic                 w_err_now;
    logic                 r_mask_err;
    logic [NUM_BANKS-1:0] w_busy;
    logic [RD_LAT-1:0]    r_pv;
    logic [NUM_BANKS-1:0] r_pm [RD_LAT];

    // Grants are suppressed while reset is held so outputs read as idle.
    assign w_rd_elig = !rst && rd_req && (rd_mask != '0) && ((rd_mask & w_busy) == '0);
    assign w_wr_elig = !rst && wr_req && (wr_mask != '0) && ((wr_mask & w_busy) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= PTR_RD;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        w_rd_gnt  = 1'b0;
        w_wr_gnt  = 1'b0;
        if (w_rd_elig && (!w_wr_elig || r_ptr == PTR_RD)) begin
            w_rd_gnt  = 1'b1;
            w_ptr_nxt = PTR_WR;
        end else if (w_wr_elig) begin
            w_wr_gnt  = 1'b1;
            w_ptr_nxt = PTR_RD;
        end
    end

    always_comb begin
        sram_ren   = w_rd_gnt;
        sram_wen   = w_wr_gnt;
        sram_cs    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (w_rd_gnt) begin
            sram_cs   = rd_mask;
            sram_addr = rd_addr;
        end else if (w_wr_gnt) begin
            sram_cs    = wr_mask;
            sram_addr  = wr_addr;
            sram_wdata = wr_data;
        end
    end

    assign rd_gnt = w_rd_gnt;
    assign wr_gnt = w_wr_gnt;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        sram_bank_timer #(.GAP(BANK_GAP)) u_timer (
            .clk    (clk),
            .rst    (rst),
            .i_load (sram_cs[g]),
            .o_busy (w_busy[g])
        );
        assign rd_data[g*LANE_W +: LANE_W] = rd_vmask[g] ? sram_rdata[g*LANE_W +: LANE_W] : '0;
    end

    assign bank_busy = w_busy;

    assign w_err_now = !rst && ((rd_req && rd_mask == '0) || (wr_req && wr_mask == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask_err <= 1'b0;
        end else begin
            r_mask_err <= r_mask_err | w_err_now;
        end
    end

    assign mask_err = r_mask_err | w_err_now;

    // Non-issue slots carry a zero mask so the tail mask doubles as the return mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pm[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_rd_gnt;
            r_pm[0] <= w_rd_gnt ? rd_mask : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pm[i] <= r_pm[i-1];
            end
        end
    end

    assign rd_valid = r_pv[RD_LAT-1];
    assign rd_vmask = r_pm[RD_LAT-1];
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: cycle-level model built from bank
// issue times, a grant pointer bit and a return-cycle table.
module tb_sram_arbiter;
    localparam int NB  = 4;
    localparam int GAP = 5;
    localparam int LAT = 5;
    localparam int DW  = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req, wr_req;
    logic [9:0]    rd_addr, wr_addr;
    logic [NB-1:0] rd_mask, wr_mask;
    logic [DW-1:0] wr_data, sram_rdata;
    logic          rd_gnt, wr_gnt, rd_valid, sram_ren, sram_wen, mask_err;
    logic [NB-1:0] rd_vmask, sram_cs, bank_busy;
    logic [DW-1:0] rd_data, sram_wdata;
    logic [9:0]    sram_addr;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_mask(rd_mask), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_vmask(rd_vmask), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
        .wr_gnt(wr_gnt), .sram_ren(sram_ren), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_cs(sram_cs), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .bank_busy(bank_busy), .mask_err(mask_err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int            last_g [NB];
    bit            m_ptr_wr;
    bit            m_err;
    logic [NB-1:0] ret_mask [int];

    bit            g_rd, g_wr, obs_valid, obs_err;
    logic [NB-1:0] obs_busy, obs_cs, obs_vmask;
    logic [DW-1:0] obs_data, obs_rdata;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_wide();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock cycle: compare against the model at mid-cycle, advance model, cross the edge.
    task automatic step();
        logic [NB-1:0] busy, e_cs, e_vm;
        logic [9:0]    e_addr;
        logic [DW-1:0] e_wd, e_rdata;
        bit            rd_el, wr_el, e_rd, e_wr, e_v, e_err;
        busy = '0; e_cs = '0; e_vm = '0; e_addr = '0; e_wd = '0; e_rdata = '0;
        e_rd = 0; e_wr = 0; e_v = 0; e_err = 0;
        sram_rdata = rnd_wide();
        #1;
        if (rst) begin
            for (int b = 0; b < NB; b++) last_g[b] = -100;
            m_ptr_wr = 0;
            m_err    = 0;
            ret_mask.delete();
        end else begin
            for (int b = 0; b < NB; b++)
                busy[b] = (cyc >= last_g[b] + 1) && (cyc <= last_g[b] + GAP);
            rd_el = rd_req && (rd_mask != 0) && ((rd_mask & busy) == 0);
            wr_el = wr_req && (wr_mask != 0) && ((wr_mask & busy) == 0);
            e_rd  = rd_el && (!wr_el || !m_ptr_wr);
            e_wr  = wr_el && !e_rd;
            if (e_rd) begin
                e_cs = rd_mask; e_addr = rd_addr;
                ret_mask[cyc + LAT] = rd_mask;
                m_ptr_wr = 1;
            end else if (e_wr) begin
                e_cs = wr_mask; e_addr = wr_addr; e_wd = wr_data;
                m_ptr_wr = 0;
            end
            for (int b = 0; b < NB; b++) if (e_cs[b]) last_g[b] = cyc;
            e_err = m_err || (rd_req && rd_mask == 0) || (wr_req && wr_mask == 0);
            m_err = e_err;
            if (ret_mask.exists(cyc)) begin
                e_v  = 1;
                e_vm = ret_mask[cyc];
                ret_mask.delete(cyc);
            end
            for (int b = 0; b < NB; b++)
                if (e_vm[b]) e_rdata[b*64 +: 64] = sram_rdata[b*64 +: 64];
        end
        chk("rd_gnt", rd_gnt, e_rd);
        chk("wr_gnt", wr_gnt, e_wr);
        chk("sram_ren", sram_ren, e_rd);
        chk("sram_wen", sram_wen, e_wr);
        chk("sram_cs", sram_cs, e_cs);
        chk("sram_addr", sram_addr, e_addr);
        chk("sram_wdata", sram_wdata, e_wd);
        chk("bank_busy", bank_busy, busy);
        chk("mask_err", mask_err, e_err);
        chk("rd_valid", rd_valid, e_v);
        chk("rd_vmask", rd_vmask, e_vm);
        chk("rd_data", rd_data, e_rdata);
        g_rd = rd_gnt; g_wr = wr_gnt; obs_valid = rd_valid; obs_err = mask_err;
        obs_busy = bank_busy; obs_cs = sram_cs; obs_vmask = rd_vmask;
        obs_data = rd_data; obs_rdata = sram_rdata;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rd_req = 0; wr_req = 0; rd_mask = '0; wr_mask = '0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    int seq [4];
    int n_g;
    int first_rd;

    initial begin
        idle_inputs();
        sram_rdata = '0;
        rst = 1;
        @(negedge clk);
        do_reset();

        // Single read to bank 0 returns after LAT cycles with only lane 0 populated.
        rd_req = 1; rd_mask = 4'b0001; rd_addr = 10'h005;
        step();
        chk("t042_gnt", g_rd, 1'b1);
        chk("t042_cs", obs_cs, 4'b0001);
        idle_inputs();
        repeat (LAT - 1) begin
            step();
            chk("t042_early", obs_valid, 1'b0);
        end
        step();
        chk("t042_valid", obs_valid, 1'b1);
        chk("t042_vmask", obs_vmask, 4'b0001);
        chk("t042_lane0", obs_data[63:0], obs_rdata[63:0]);
        chk("t042_upper", obs_data[255:64], '0);

        // Both requesters held on disjoint banks: grants alternate, read first.
        do_reset();
        for (int i = 0; i < 4; i++) seq[i] = 2;
        n_g = 0;
        rd_req = 1; rd_mask = 4'b0001; wr_req = 1; wr_mask = 4'b0010;
        wr_data = rnd_wide();
        for (int k = 0; k < 40 && n_g < 4; k++) begin
            step();
            if (g_rd) begin seq[n_g] = 1; n_g++; end
            else if (g_wr) begin seq[n_g] = 0; n_g++; end
        end
        chk("t043_g0", seq[0], 1);
        chk("t043_g1", seq[1], 0);
        chk("t043_g2", seq[2], 1);
        chk("t043_g3", seq[3], 0);

        // A lone read grant still hands priority to the write.
        do_reset();
        rd_req = 1; rd_mask = 4'b0100;
        step();
        chk("t030_rd_alone", g_rd, 1'b1);
        rd_mask = 4'b0001; wr_req = 1; wr_mask = 4'b0010;
        step();
        chk("t030_wr_wins", g_wr, 1'b1);
        chk("t030_rd_held", g_rd, 1'b0);

        // Write to bank 0 locks out a following read until T+GAP+1.
        do_reset();
        wr_req = 1; wr_mask = 4'b0001; wr_addr = 10'h3a1; wr_data = rnd_wide();
        step();
        chk("t044_wr_gnt", g_wr, 1'b1);
        idle_inputs();
        rd_req = 1; rd_mask = 4'b0001; rd_addr = 10'h011;
        first_rd = -1;
        for (int k = 1; k <= 10 && first_rd < 0; k++) begin
            step();
            if (k <= GAP) chk("t044_busy0", obs_busy[0], 1'b1);
            if (g_rd) first_rd = k;
        end
        chk("t044_first_rd", first_rd, GAP + 1);
        idle_inputs();

        // All-zero mask is never granted and latches the error.
        do_reset();
        rd_req = 1; rd_mask = 4'b0000; rd_addr = 10'h0ff;
        repeat (6) begin
            step();
            chk("t045_no_gnt", g_rd, 1'b0);
            chk("t045_no_cs", obs_cs, '0);
            chk("t045_err", obs_err, 1'b1);
        end
        idle_inputs();
        repeat (3) step();
        chk("t045_sticky", obs_err, 1'b1);

        // Reset with reads in flight drops them and clears lockouts.
        do_reset();
        rd_req = 1; rd_mask = 4'b0001;
        step();
        rd_mask = 4'b0010;
        step();
        chk("t046_two_grants", g_rd, 1'b1);
        idle_inputs();
        step();
        rst = 1;
        step();
        rst = 0;
        step();
        chk("t046_busy_clr", obs_busy, '0);
        repeat (10) begin
            step();
            chk("t046_no_valid", obs_valid, 1'b0);
        end

        // Randomized traffic.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            if (rd_req && (g_rd || $urandom_range(0, 31) == 0)) rd_req = 0;
            else if (!rd_req && $urandom_range(0, 2) == 0) begin
                rd_req  = 1;
                rd_mask = 4'($urandom_range(0, 15));
                if (rd_mask == 0 && $urandom_range(0, 3) != 0) rd_mask = 4'b1000;
                rd_addr = 10'($urandom);
            end
            if (wr_req && (g_wr || $urandom_range(0, 31) == 0)) wr_req = 0;
            else if (!wr_req && $urandom_range(0, 2) == 0) begin
                wr_req  = 1;
                wr_mask = 4'($urandom_range(0, 15));
                if (wr_mask == 0 && $urandom_range(0, 3) != 0) wr_mask = 4'b0001;
                wr_addr = 10'($urandom);
                wr_data = rnd_wide();
            end
            rst = ($urandom_range(0, 499) == 0);
            step();
            if (rst) begin
                rst = 0;
                g_rd = 0; g_wr = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
